// File: rtl/pingpong_wr_ctrl.sv
// Write-side sequencer filling two ping-pong banks of a dual-port memory; writes land at the same wclk edge (zero latency).
// in_ready drops (STALL) only when the bank being switched to is still owned by the consumer; it rises one cycle after that bank is released.
module pingpong_wr_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                in_valid,
  input  logic [DATASIZE-1:0] in_data,
  output logic                in_ready,
  input  logic                flush,
  input  logic                rel_valid,
  input  logic                rel_bank,
  output logic [DATASIZE-1:0] mem_wdata,
  output logic [ADDRSIZE-1:0] mem_waddr,
  output logic                mem_wclken,
  output logic                mem_wfull,
  output logic [1:0]          bank_vld,
  output logic [ADDRSIZE-1:0] bank_len0,
  output logic [ADDRSIZE-1:0] bank_len1,
  output logic                cur_bank,
  output logic                rel_err
);

  localparam int PW = ADDRSIZE - 1;

  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_cur_bank;
  logic [PW-1:0]       r_wptr;
  logic [1:0]          r_bank_vld;
  logic [1:0]          w_bank_vld_nxt;
  logic [ADDRSIZE-1:0] r_len0;
  logic [ADDRSIZE-1:0] r_len1;
  logic                r_rel_err;

  logic                w_wr;
  logic                w_close;
  logic                w_rel_ok;
  logic                w_nxt_bank;
  logic [ADDRSIZE-1:0] w_len;

  assign in_ready   = (r_state == ST_FILL);
  assign w_wr       = in_valid & in_ready;
  assign w_nxt_bank = ~r_cur_bank;
  assign w_rel_ok   = rel_valid & r_bank_vld[rel_bank];

  // Full-bank close or early flush; a flush on an empty bank publishes nothing.
  assign w_close = in_ready &
                   ((w_wr & (r_wptr == {PW{1'b1}})) |
                    (flush & ((r_wptr != {PW{1'b0}}) | w_wr)));

  // One bit wider than wptr so a full bank reports BDEPTH rather than wrapping to 0.
  assign w_len = {1'b0, r_wptr} + {{PW{1'b0}}, w_wr};

  assign mem_wclken = w_wr;
  assign mem_wdata  = in_data;
  assign mem_waddr  = {r_cur_bank, r_wptr};
  assign mem_wfull  = ~in_ready;
  assign bank_vld   = r_bank_vld;
  assign bank_len0  = r_len0;
  assign bank_len1  = r_len1;
  assign cur_bank   = r_cur_bank;
  assign rel_err    = r_rel_err;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        // A release of the incoming bank in the closing cycle avoids the stall bubble.
        if (w_close && r_bank_vld[w_nxt_bank] &&
            !(w_rel_ok && (rel_bank == w_nxt_bank))) begin
          w_state_nxt = ST_STALL;
        end
      end
      ST_STALL: begin
        if (w_rel_ok && (rel_bank == r_cur_bank)) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  // A legal release and a close never target the same bank: the closing bank is not valid yet.
  always_comb begin
    w_bank_vld_nxt = r_bank_vld;
    if (w_rel_ok) begin
      w_bank_vld_nxt[rel_bank] = 1'b0;
    end
    if (w_close) begin
      w_bank_vld_nxt[r_cur_bank] = 1'b1;
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_cur_bank <= 1'b0;
      r_wptr     <= {PW{1'b0}};
    end else if (w_close) begin
      r_cur_bank <= w_nxt_bank;
      r_wptr     <= {PW{1'b0}};
    end else if (w_wr) begin
      r_wptr     <= r_wptr + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_bank_vld <= 2'b00;
      r_len0     <= {ADDRSIZE{1'b0}};
      r_len1     <= {ADDRSIZE{1'b0}};
      r_rel_err  <= 1'b0;
    end else begin
      r_bank_vld <= w_bank_vld_nxt;
      if (w_rel_ok && (rel_bank == 1'b0)) begin
        r_len0 <= {ADDRSIZE{1'b0}};
      end
      if (w_rel_ok && (rel_bank == 1'b1)) begin
        r_len1 <= {ADDRSIZE{1'b0}};
      end
      if (w_close && (r_cur_bank == 1'b0)) begin
        r_len0 <= w_len;
      end
      if (w_close && (r_cur_bank == 1'b1)) begin
        r_len1 <= w_len;
      end
      if (rel_valid && !r_bank_vld[rel_bank]) begin
        r_rel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Directed bench for pingpong_wr_ctrl: fill/close, stall/release, flush, same-cycle close+release, rel_err, async reset.
module tb_pingpong_wr_ctrl;

  localparam int DATASIZE = 8;
  localparam int ADDRSIZE = 4;

  logic                wclk;
  logic                wrst_n;
  logic                in_valid;
  logic [DATASIZE-1:0] in_data;
  logic                in_ready;
  logic                flush;
  logic                rel_valid;
  logic                rel_bank;
  logic [DATASIZE-1:0] mem_wdata;
  logic [ADDRSIZE-1:0] mem_waddr;
  logic                mem_wclken;
  logic                mem_wfull;
  logic [1:0]          bank_vld;
  logic [ADDRSIZE-1:0] bank_len0;
  logic [ADDRSIZE-1:0] bank_len1;
  logic                cur_bank;
  logic                rel_err;

  int checks = 0;
  int errors = 0;

  pingpong_wr_ctrl #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE)) dut (
    .wclk       (wclk),
    .wrst_n     (wrst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .flush      (flush),
    .rel_valid  (rel_valid),
    .rel_bank   (rel_bank),
    .mem_wdata  (mem_wdata),
    .mem_waddr  (mem_waddr),
    .mem_wclken (mem_wclken),
    .mem_wfull  (mem_wfull),
    .bank_vld   (bank_vld),
    .bank_len0  (bank_len0),
    .bank_len1  (bank_len1),
    .cur_bank   (cur_bank),
    .rel_err    (rel_err)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    wrst_n    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    rel_valid = 1'b0;
    rel_bank  = 1'b0;
    #2;
    check("rst_bank_vld", 32'(bank_vld), 32'h0);
    check("rst_cur_bank", 32'(cur_bank), 32'h0);
    check("rst_len0",     32'(bank_len0), 32'h0);
    check("rst_rel_err",  32'(rel_err), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_wfull",    32'(mem_wfull), 32'h0);
    tick();
    wrst_n = 1'b1;
    tick();

    // Fill bank 0 with 0x10..0x17
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h10 + i);
      #1;
      check("b0_waddr",  32'(mem_waddr), 32'(i));
      check("b0_wdata",  32'(mem_wdata), 32'(8'h10 + i));
      check("b0_wclken", 32'(mem_wclken), 32'h1);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("b0_close_vld",   32'(bank_vld), 32'h1);
    check("b0_close_len0",  32'(bank_len0), 32'h8);
    check("b0_close_cur",   32'(cur_bank), 32'h1);
    check("b0_close_ready", 32'(in_ready), 32'h1);

    // Fill bank 1 without releasing bank 0 -> stall
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h20 + i);
      #1;
      check("b1_waddr", 32'(mem_waddr), 32'(8 + i));
      tick();
    end
    #1;
    check("stall_vld",    32'(bank_vld), 32'h3);
    check("stall_len1",   32'(bank_len1), 32'h8);
    check("stall_ready",  32'(in_ready), 32'h0);
    check("stall_wfull",  32'(mem_wfull), 32'h1);
    check("stall_wclken", 32'(mem_wclken), 32'h0);
    in_valid  = 1'b0;
    rel_valid = 1'b1;
    rel_bank  = 1'b0;
    #1;
    check("rel_cycle_ready", 32'(in_ready), 32'h0);
    tick();
    rel_valid = 1'b0;
    #1;
    check("unstall_vld",   32'(bank_vld), 32'h2);
    check("unstall_ready", 32'(in_ready), 32'h1);
    check("unstall_waddr", 32'(mem_waddr), 32'h0);
    check("unstall_len0",  32'(bank_len0), 32'h0);

    // Three writes, flush with the fourth
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h30 + i);
      flush    = (i == 3);
      #1;
      check("fl_waddr", 32'(mem_waddr), 32'(i));
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    #1;
    check("fl_len0",  32'(bank_len0), 32'h4);
    check("fl_vld",   32'(bank_vld), 32'h3);
    check("fl_cur",   32'(cur_bank), 32'h1);
    check("fl_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    check("fl_ign_vld", 32'(bank_vld), 32'h3);
    check("fl_ign_cur", 32'(cur_bank), 32'h1);

    // Release bank 1 -> fill bank 1; empty flush is ignored
    rel_valid = 1'b1;
    rel_bank  = 1'b1;
    tick();
    rel_valid = 1'b0;
    #1;
    check("r1_vld",   32'(bank_vld), 32'h1);
    check("r1_ready", 32'(in_ready), 32'h1);
    check("r1_len1",  32'(bank_len1), 32'h0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("efl_vld",  32'(bank_vld), 32'h1);
    check("efl_cur",  32'(cur_bank), 32'h1);
    check("efl_addr", 32'(mem_waddr), 32'h8);

    // Eighth write to bank 1 coincides with release of bank 0 -> no stall
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_data   = 8'(8'h40 + i);
      rel_valid = (i == 7);
      rel_bank  = 1'b0;
      #1;
      check("cr_waddr", 32'(mem_waddr), 32'(8 + i));
      tick();
    end
    rel_valid = 1'b0;
    in_data   = 8'h50;
    #1;
    check("cr_ready",  32'(in_ready), 32'h1);
    check("cr_vld",    32'(bank_vld), 32'h2);
    check("cr_len1",   32'(bank_len1), 32'h8);
    check("cr_len0",   32'(bank_len0), 32'h0);
    check("cr_cur",    32'(cur_bank), 32'h0);
    check("cr_waddr0", 32'(mem_waddr), 32'h0);
    check("cr_wclken", 32'(mem_wclken), 32'h1);
    tick();
    in_valid = 1'b0;

    // Release bank 1 legally, then again illegally
    rel_valid = 1'b1;
    rel_bank  = 1'b1;
    tick();
    #1;
    check("rl_vld",  32'(bank_vld), 32'h0);
    check("rl_err0", 32'(rel_err), 32'h0);
    tick();
    rel_valid = 1'b0;
    #1;
    check("re_err",   32'(rel_err), 32'h1);
    check("re_vld",   32'(bank_vld), 32'h0);
    check("re_cur",   32'(cur_bank), 32'h0);
    check("re_ready", 32'(in_ready), 32'h1);
    check("re_waddr", 32'(mem_waddr), 32'h1);

    // Four writes (addr 1..4), then flush with illegal release of the closing bank
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h60 + i);
      #1;
      check("tr_waddr", 32'(mem_waddr), 32'(1 + i));
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b1;
    rel_valid = 1'b1;
    rel_bank  = 1'b0;
    tick();
    flush     = 1'b0;
    rel_valid = 1'b0;
    #1;
    check("ic_len0",  32'(bank_len0), 32'h5);
    check("ic_vld",   32'(bank_vld), 32'h1);
    check("ic_cur",   32'(cur_bank), 32'h1);
    check("ic_ready", 32'(in_ready), 32'h1);
    check("ic_err",   32'(rel_err), 32'h1);

    // Five writes into bank 1, then async reset mid-fill
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h70 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("mf_waddr", 32'(mem_waddr), 32'hD);
    check("mf_err",   32'(rel_err), 32'h1);
    wrst_n = 1'b0;
    #1;
    check("ar_vld",   32'(bank_vld), 32'h0);
    check("ar_cur",   32'(cur_bank), 32'h0);
    check("ar_len0",  32'(bank_len0), 32'h0);
    check("ar_err",   32'(rel_err), 32'h0);
    check("ar_waddr", 32'(mem_waddr), 32'h0);
    check("ar_ready", 32'(in_ready), 32'h1);
    tick();
    wrst_n   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #1;
    check("pr_waddr",  32'(mem_waddr), 32'h0);
    check("pr_wclken", 32'(mem_wclken), 32'h1);
    tick();
    in_valid = 1'b0;
    #1;
    check("pr_waddr1", 32'(mem_waddr), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_wr_ctrl.md
Name: pingpong_wr_ctrl

Overview:
Write-side sequencer for the dual-port FIFO memory, operated as two ping-pong banks. The bank is selected by the MSB of the write address. It accepts a valid/ready input stream and generates the memory write address and enable. It closes a bank when the bank fills or when flush is asserted, publishes the bank's valid flag and word count, and then switches to the other bank. The consumer returns a bank by releasing it; the release request is already synchronous to wclk.

Parameters:
DATASIZE, 8, memory data word width
ADDRSIZE, 4, memory address bits; bank depth BDEPTH = 2^(ADDRSIZE-1) (8 at default)

Ports:
wclk  input  1  write clock; the only clock
wrst_n  input  1  asynchronous active-low reset
in_valid  input  1  input word valid
in_data  input  DATASIZE  input word
in_ready  output  1  controller can accept a word this cycle
flush  input  1  close the current bank early, even if partially filled
rel_valid  input  1  consumer releases a bank (one-cycle pulse)
rel_bank  input  1  index of the bank being released
mem_wdata  output  DATASIZE  to memory wdata
mem_waddr  output  ADDRSIZE  to memory waddr = {cur_bank, wptr}
mem_wclken  output  1  to memory wclken
mem_wfull  output  1  to memory wfull = ~in_ready
bank_vld  output  2  bank holds closed data owned by the consumer
bank_len0  output  ADDRSIZE  word count of bank 0, range 0..BDEPTH
bank_len1  output  ADDRSIZE  word count of bank 1
cur_bank  output  1  bank currently being filled
rel_err  output  1  sticky flag: release of a bank that is not valid

Behaviour:
- Reset (asynchronous, wrst_n=0): state=FILL, cur_bank=0, wptr=0, bank_vld=00, bank_len0/1=0, rel_err=0. Consequently in_ready=1 as soon as reset deasserts.
- Write accept: wr = in_valid & in_ready.
  - mem_wclken = wr, mem_wdata = in_data, mem_waddr = {cur_bank, wptr}; all combinational.
  - The word is written at the same wclk edge; there is no extra latency.
- FSM states:
  - FILL: in_ready=1.
  - STALL: in_ready=0; entered when the bank just switched to is still valid (bank_vld[cur_bank]=1).
- Close condition, evaluated each cycle in FILL:
  - close = (wr & wptr==BDEPTH-1) | (flush & (wptr!=0 | wr)).
  - Length on close: len = wptr + wr, computed in ADDRSIZE bits, so a full bank gives len=BDEPTH.
- On close, at the clock edge:
  - bank_vld[cur_bank] <= 1.
  - bank_len[cur_bank] <= len.
  - wptr <= 0.
  - cur_bank <= ~cur_bank.
  - Next state is STALL if the new bank is valid and is not being released this same cycle; otherwise FILL.
- Without close: wptr <= wptr + wr; wptr wraps only through the close path.
- flush with wptr==0 and no write: ignored; no empty bank is published.
- flush while in STALL: ignored. The flush is not remembered.
- Release, when rel_valid and bank_vld[rel_bank]=1:
  - bank_vld[rel_bank] <= 0; bank_len of that bank <= 0.
  - If in STALL and rel_bank==cur_bank, go to FILL next cycle; in_ready rises one cycle after the release pulse.
- Release of a bank whose bank_vld=0: no state change; rel_err <= 1 (sticky until reset).
- Release and close in the same cycle:
  - Close of bank X with release of bank ~X (the bank about to be filled) → next state FILL, no stall bubble.
  - Release of bank X while X is being closed cannot be legal, because X is not valid yet → rel_err; the close still completes.
- bank_vld and bank_len are registered; they become visible the cycle after the closing write.
- The memory read is asynchronous, so the consumer may read a bank immediately once its bank_vld is seen.
- Reset mid-operation: all bank contents are logically discarded (bank_vld=00). The memory array itself is not cleared.

Test Plan:
- Reset, then 8 consecutive writes of 0x10..0x17 → mem_waddr 0..7. The cycle after the 8th write: bank_vld=01, bank_len0=8, cur_bank=1, in_ready=1.
- Continue with 8 more words without releasing bank 0 → writes to addresses 8..15, then bank_vld=11, state STALL, in_ready=0, mem_wfull=1. Pulse rel_valid with rel_bank=0 → next cycle bank_vld=10, in_ready=1, mem_waddr=0.
- Write 3 words, then assert flush together with the 4th write → bank_len0=4 and bank_vld[0]=1. A flush on the next cycle with no write is ignored: bank_vld is unchanged and cur_bank stays 1.
- Same-cycle close and release: bank1 is valid, bank0 is filling, and the 8th write to bank0 coincides with release of bank1 → no STALL cycle; the next write goes to address 8 with bank_vld=01.
- Release of bank 1 while bank_vld=00 → rel_err=1 and no other state change; rel_err stays high across later traffic until wrst_n is pulsed.
- Assert wrst_n low mid-fill (wptr=5, bank_vld=01) → outputs return to reset values immediately (asynchronously); after release, the first write goes to address 0.
